bram_stream_reader: RTL

Sequential read engine that sits directly downstream of the team's block RAM primitive. It walks a contiguous address range, drives the RAM read port (`rd_en`/`rd_addr`), absorbs the RAM's fixed read latency, and presents the words as a valid/ready stream to the next compute stage. A small skid FIFO keeps throughput at one word per cycle under arbitrary consumer back-pressure, with no lost or duplicated words.

---
 rtl/bram_stream_reader_pkg.sv | 17 +
 rtl/bram_stream_reader_skid_fifo.sv | 96 +++++++++
 rtl/bram_stream_reader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_reader_pkg.sv
// Shared types for the BRAM stream reader: FSM state encoding and the
// read-latency legality check.
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Only RAMs with or without the optional output register are supported.
  function automatic bit read_latency_ok(input int lat);
    return (lat == 32'sd1) || (lat == 32'sd2);
  endfunction

endpackage

// File: rtl/bram_stream_reader_skid_fifo.sv
// Register-based skid FIFO (width, depth) with push/pop/count, plus a
// simulation checker that flags a push into a full FIFO without a pop.
module skid_fifo #(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 32'sd1),
  localparam int PW    = (DEPTH > 32'sd1) ? $clog2(DEPTH) : 32'sd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointers wrap explicitly because DEPTH is usually not a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 32'sd1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  // Flag decode and head/count presentation.
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    empty     = (count_r == {CW{1'b0}});
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full_s || pop_ok_s);
    head_data = mem_r[rd_ptr_r];
    count     = count_r;
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  skid_fifo_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop_ok_s),
    .full  (full_s)
  );

endmodule

module skid_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic pop,
  input logic full
);

  // A push into a full FIFO is only legal alongside a pop.
  always @(posedge clk) begin
    if (rst_n) begin
      a_no_overflow: assert (!(push && full && !pop));
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Sequential BRAM read engine streaming a contiguous address range as
// valid/ready words. Optional o_last port: BRAM_STREAM_READER_LAST_EN.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int  DATA_WIDTH   = 32,
  parameter int  DEPTH        = 65536,
  parameter int  READ_LATENCY = 1,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           length,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_rd_en,
  output logic [AW-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  o_ready
`ifdef BRAM_STREAM_READER_LAST_EN
  ,
  output logic                  o_last
`endif
);

  localparam int FIFO_DEPTH = READ_LATENCY + 32'sd1;
  localparam int CW         = $clog2(FIFO_DEPTH + 32'sd1);
  localparam int OW         = 4;
`ifdef BRAM_STREAM_READER_LAST_EN
  localparam int FW         = DATA_WIDTH + 32'sd1;
`else
  localparam int FW         = DATA_WIDTH;
`endif

  state_e                  state_r;
  state_e                  state_s;
  logic [AW-1:0]           addr_r;
  logic [AW:0]             remain_r;
  logic [READ_LATENCY-1:0] inflight_r;
  logic                    issue_s;
  logic                    last_issue_s;
  logic                    pop_s;
  logic                    push_s;
  logic [OW-1:0]           inflight_cnt_s;
  logic [OW-1:0]           occ_s;
  logic [OW-1:0]           occ_after_pop_s;
  logic [CW-1:0]           fifo_cnt_s;
  logic                    fifo_empty_s;
  logic [FW-1:0]           push_word_s;
  logic [FW-1:0]           head_word_s;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    if (a == AW'(DEPTH - 32'sd1)) begin
      return {AW{1'b0}};
    end else begin
      return a + AW'(1'b1);
    end
  endfunction

  // Occupancy and issue decision; occupancy counts words already promised a FIFO slot.
  always_comb begin
    inflight_cnt_s = {OW{1'b0}};
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_cnt_s = inflight_cnt_s + OW'(inflight_r[i]);
    end
    pop_s           = !fifo_empty_s && o_ready;
    occ_s           = inflight_cnt_s + OW'(fifo_cnt_s);
    occ_after_pop_s = occ_s - OW'(pop_s);
    issue_s         = (state_r == ST_RUN) && (occ_after_pop_s < OW'(FIFO_DEPTH));
    last_issue_s    = issue_s && (remain_r == (AW+1)'(1'b1));
    push_s          = inflight_r[READ_LATENCY-1];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (length == {(AW+1){1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_issue_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (occ_after_pop_s == {OW{1'b0}}) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM and stream outputs.
  always_comb begin
    busy        = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    done        = (state_r == ST_DONE);
    ram_rd_en   = issue_s;
    ram_rd_addr = addr_r;
    o_valid     = !fifo_empty_s;
    o_data      = head_word_s[DATA_WIDTH-1:0];
`ifdef BRAM_STREAM_READER_LAST_EN
    o_last      = head_word_s[DATA_WIDTH];
`endif
  end

  // Address/remaining counters and the issue-flag delay line matching RAM latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_r     <= {AW{1'b0}};
      remain_r   <= {(AW+1){1'b0}};
      inflight_r <= {READ_LATENCY{1'b0}};
    end else begin
      if ((state_r == ST_IDLE) && start) begin
        addr_r   <= base_addr;
        remain_r <= length;
      end else if (issue_s) begin
        addr_r   <= addr_inc(addr_r);
        remain_r <= remain_r - (AW+1)'(1'b1);
      end
      inflight_r <= READ_LATENCY'({inflight_r, issue_s});
    end
  end

`ifdef BRAM_STREAM_READER_LAST_EN
  logic [READ_LATENCY-1:0] last_pipe_r;

  // Last-word marker delayed alongside the issue flag so it lands with its data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_pipe_r <= {READ_LATENCY{1'b0}};
    end else begin
      last_pipe_r <= READ_LATENCY'({last_pipe_r, last_issue_s});
    end
  end

  // FIFO word carries the last marker above the data.
  always_comb begin
    push_word_s = {last_pipe_r[READ_LATENCY-1], ram_rd_data};
  end
`else
  // FIFO word is the raw RAM data.
  always_comb begin
    push_word_s = ram_rd_data;
  end
`endif

  skid_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_word_s),
    .pop       (pop_s),
    .head_data (head_word_s),
    .count     (fifo_cnt_s),
    .empty     (fifo_empty_s)
  );

  bram_stream_reader_chk #(
    .READ_LATENCY (READ_LATENCY)
  ) u_chk (
    .clk (clk)
  );

endmodule

module bram_stream_reader_chk
  import bram_stream_reader_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input logic clk
);

  // RAM latency must be one of the supported build options.
  always @(posedge clk) begin
    a_latency_legal: assert (read_latency_ok(READ_LATENCY));
  end

endmodule
